// File: rtl/rv32_pkg.sv
// Shared RV32I encoding types: format codes, opcodes, instruction word and field bundle.
// Optional build macro IMM_RANGE_CHECK_EN is consumed by inst_field_encoder, not here.
package rv32_pkg;

    localparam int REG_W = 5;

    typedef logic [31:0] inst_t;
    typedef logic [2:0]  fmt_t;

    localparam fmt_t FMT_R = 3'd0;
    localparam fmt_t FMT_I = 3'd1;
    localparam fmt_t FMT_S = 3'd2;
    localparam fmt_t FMT_B = 3'd3;
    localparam fmt_t FMT_U = 3'd4;
    localparam fmt_t FMT_J = 3'd5;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef struct packed {
        fmt_t             fmt;
        logic [6:0]       opcode;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        logic [31:0]      imm;
    } fields_t;

endpackage

// File: rtl/inst_pack_comb.sv
// Pure combinational packer: field bundle -> RV32I word, flags illegal format codes.
// Fields a format does not use never reach the word.
module inst_pack_comb
    import rv32_pkg::*;
(
    input  fields_t fields,
    output inst_t   inst,
    output logic    fmt_err
);

    always_comb begin
        inst    = '0;
        fmt_err = 1'b0;
        case (fields.fmt)
            FMT_R: inst = {fields.funct7, fields.rs2, fields.rs1,
                           fields.funct3, fields.rd, fields.opcode};
            FMT_I: inst = {fields.imm[11:0], fields.rs1,
                           fields.funct3, fields.rd, fields.opcode};
            FMT_S: inst = {fields.imm[11:5], fields.rs2, fields.rs1,
                           fields.funct3, fields.imm[4:0], fields.opcode};
            FMT_B: inst = {fields.imm[12], fields.imm[10:5],
                           fields.rs2, fields.rs1, fields.funct3,
                           fields.imm[4:1], fields.imm[11], fields.opcode};
            FMT_U: inst = {fields.imm[31:12], fields.rd, fields.opcode};
            FMT_J: inst = {fields.imm[20], fields.imm[10:1], fields.imm[11],
                           fields.imm[19:12], fields.rd, fields.opcode};
            default: fmt_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_field_encoder.sv
// RV32I field encoder with registered valid/ready output stage and one skid entry.
// Define IMM_RANGE_CHECK_EN to also flag immediates that do not fit their format.
module inst_field_encoder
    import rv32_pkg::*;
#(
    parameter int inst_width = 32,
    parameter int num_width  = 5,
    parameter int cnt_width  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_fmt,
    input  logic [6:0]            in_opcode,
    input  logic [num_width-1:0]  in_rd,
    input  logic [num_width-1:0]  in_rs1,
    input  logic [num_width-1:0]  in_rs2,
    input  logic [2:0]            in_funct3,
    input  logic [6:0]            in_funct7,
    input  logic [31:0]           in_imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [inst_width-1:0] out_inst,
    output logic                  out_err,
    output logic [cnt_width-1:0]  out_cnt
);

    fields_t fields;
    inst_t   packed_inst;
    logic    fmt_err;
    logic    new_err;

    always_comb begin
        fields.fmt    = in_fmt;
        fields.opcode = in_opcode;
        fields.rd     = in_rd;
        fields.rs1    = in_rs1;
        fields.rs2    = in_rs2;
        fields.funct3 = in_funct3;
        fields.funct7 = in_funct7;
        fields.imm    = in_imm;
    end

    inst_pack_comb u_pack (
        .fields  (fields),
        .inst    (packed_inst),
        .fmt_err (fmt_err)
    );

`ifdef IMM_RANGE_CHECK_EN
    logic imm_bad;

    // Upper bits must be a pure sign extension of the encodable field.
    always_comb begin
        imm_bad = 1'b0;
        case (in_fmt)
            FMT_I, FMT_S:
                imm_bad = in_imm[31:11] != {21{in_imm[11]}};
            FMT_B:
                imm_bad = (in_imm[31:12] != {20{in_imm[12]}}) | in_imm[0];
            FMT_J:
                imm_bad = (in_imm[31:20] != {12{in_imm[20]}}) | in_imm[0];
            FMT_U:
                imm_bad = in_imm[11:0] != 12'h000;
            default:
                imm_bad = 1'b0;
        endcase
    end

    assign new_err = fmt_err | imm_bad;
`else
    assign new_err = fmt_err;
`endif

    logic  skid_valid;
    inst_t skid_inst;
    logic  skid_err;
    logic  accept;
    logic  drain;
    logic  load_out;

    assign in_ready = !skid_valid;
    assign accept   = in_valid & in_ready;
    assign drain    = out_valid & out_ready;
    assign load_out = !out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_inst   <= '0;
            out_err    <= 1'b0;
            skid_valid <= 1'b0;
            skid_inst  <= '0;
            skid_err   <= 1'b0;
            out_cnt    <= '0;
        end else begin
            if (load_out) begin
                // A full skid blocks accept, so it always wins the output slot.
                if (skid_valid) begin
                    out_valid  <= 1'b1;
                    out_inst   <= skid_inst;
                    out_err    <= skid_err;
                    skid_valid <= 1'b0;
                end else if (accept) begin
                    out_valid <= 1'b1;
                    out_inst  <= packed_inst;
                    out_err   <= new_err;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (accept) begin
                skid_valid <= 1'b1;
                skid_inst  <= packed_inst;
                skid_err   <= new_err;
            end
            if (drain) begin
                out_cnt <= out_cnt + 1'b1;
            end
        end
    end

endmodule
